temp_seg_display: RTL and testbench
===================================

# temp_seg_display

Downstream consumer of the DS18B20 temperature driver. Takes the driver's `temp_data`, an unsigned magnitude in hundredths of °C, together with its `sign` flag. It converts the value to BCD with a sequential shift-add-3 engine and drives a 6-digit multiplexed 7-segment display showing `-ddd.dd`, with leading-zero blanking.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `DIGIT_HZ`, default 1000: per-digit dwell rate. `SCAN_DIV = CLK_FREQ/DIGIT_HZ` clocks per digit.

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `temp_data`, input, 20: temperature magnitude in 0.01 °C units (2500 = 25.00 °C).
- `sign`, input, 1: 1 = negative.
- `seg`, output, 8: segment drive, active-low. `seg[6:0]` = g..a, `seg[7]` = dp.
- `sel`, output, 6: digit select, active-low one-hot. `sel[5]` = leftmost (sign), `sel[0]` = hundredths.

## Operation
- **Input stage:** `temp_data` and `sign` are registered once in `clk`.
- **Clamp:** `val = (temp_data > 99999) ? 99999 : temp_data[16:0]`, giving a 17-bit value.
- **Converter FSM** (states IDLE, SHIFT, LOAD):
  - IDLE: if `valid == 0` or `{sign_r, val} != last`, latch `{sign_r, val}` into the work register, clear the 20-bit BCD accumulator, clear `shcnt`, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift `{bcd, bin}` left by 1. After the 17th shift, go to LOAD.
  - LOAD: copy the 5 BCD digits and the latched sign into the display registers, set `last` and `valid = 1`, and go to IDLE.
  - Input changes during SHIFT are ignored. They are picked up in the next IDLE cycle.
- **Display mapping:**
  - d5 shows `-` (0xBF) if sign, else blank (0xFF).
  - d4 (hundreds) is blank when 0.
  - d3 (tens) is blank when d4 and d3 are both 0.
  - d2 (units) is always shown, with dp on (`seg[7] = 0`).
  - d1 and d0 are always shown.
  - Negative zero still shows `-`.
- **Segment codes, active-low:** 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Blank = FF. dp is cleared only on d2.
- **Scan:**
  - The scan counter counts 0..`SCAN_DIV-1`.
  - On wrap, the digit index advances 0→1→…→5→0.
  - `sel` and `seg` are registered and update on the same edge.

## Timing
- **Reset values:**
  - `seg = 8'hFF`, `sel = 6'h3F` (all off).
  - Display registers are blank, `valid = 0`, FSM in IDLE.
  - Scan counter and digit index are 0.
  - The first digit (`sel = 6'b111110`) is driven on the first clock after reset release.
- **Conversion latency:**
  - Edge 0: input register captures the new value.
  - Edge 1: IDLE detects the change and latches it.
  - Edges 2–18: 17 SHIFT cycles.
  - Edge 19: LOAD.
  - The new digits reach `seg` at the first scan-digit update after LOAD.
- **First conversion:** starts in the first IDLE cycle after reset, because `valid == 0`.
- **Scan period:** each digit is active for exactly `SCAN_DIV` cycles. Full frame = `6*SCAN_DIV`.
- **Reset mid-conversion:** aborts immediately. No partial BCD ever reaches the display registers.
- **Display consistency:** display registers change only in LOAD, so a digit never shows a mix of old and new values.

## Structure
- **Package `temp_disp_pkg`:**
  - FSM state encoding.
  - Segment constants (`SEG_0` … `SEG_9`, `SEG_MINUS`, `SEG_BLANK`).
  - Clamp limit 99999.
  - Width constants (`BIN_W = 17`, `BCD_W = 20`).
- **Sub-module `bin2bcd_seq`:**
  - Contains the 17-bit to 5-digit shift-add-3 engine and its FSM.
  - Handshake: `start` pulse in; `done` pulse plus `bcd[19:0]` out.
- **Top level:** input register, clamp, change detection, blanking logic, and scan mux.

## Test plan
Benches use `SCAN_DIV = 4`.
- **Reset:** assert `rstn = 0` mid-scan → `seg = FF`, `sel = 3F` immediately. After release, `sel` steps 3E, 3D, 3B, 37, 2F, 1F, each for 4 cycles.
- **Positive value:** `temp_data = 2500`, `sign = 0` → frame d5..d0 = FF, FF, A4, 12 (5 with dp), C0, C0. Display registers update exactly 19 cycles after the input edge.
- **Negative value:** `temp_data = 5500`, `sign = 1` → BF, FF, 92, 12, C0, C0. `temp_data = 12500` → FF, F9, A4, 12, C0, C0.
- **Zero and clamp:**
  - `temp_data = 0` → FF, FF, FF, 40, C0, C0.
  - `temp_data = 150000` → FF, 90, 90, 10, 90, 90 (999.99).
- **Mid-conversion change:** change 2500 → 3125 during SHIFT. 25.00 is shown first, then 31.25 (FF, FF, B0, 79, A4, 92) after a second conversion. No intermediate digits appear.
- **Unchanged input:** hold the input constant for 1000 cycles → the FSM stays in IDLE after the first LOAD, with no further conversions.

Source files
------------

// File: rtl/temp_disp_pkg.sv
// temp_disp_pkg
//   Shared definitions for the temperature 7-segment display: converter FSM
//   encoding, active-low segment codes, clamp limit and datapath widths.
package temp_disp_pkg;

    localparam int BIN_W      = 17;
    localparam int BCD_W      = 20;
    localparam int NUM_DIGITS = 6;

    // Largest magnitude that fits in ddd.dd
    localparam logic [BIN_W-1:0] CLAMP_MAX = 17'd99999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_t;

    // Active-low codes, bit 7 = dp, bits 6..0 = g..a
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Clearing bit 7 lights the decimal point
    localparam logic [7:0] SEG_DP_MASK = 8'h7F;

    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential shift-add-3 (double dabble) converter, 17-bit binary to five
//   BCD digits. One bit per clock; a conversion takes one latch cycle,
//   17 shift cycles and one load cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; latches bin and clears the accumulator
//   ST_SHIFT | one add-3 + shift per cycle, 17 cycles
//   ST_LOAD  | result valid on bcd, done high for this one cycle
//
// Ports:
//   clk, rstn : clock, async active-low reset
//   start     : begin a conversion (honoured only when not busy)
//   bin       : binary value to convert, sampled with start
//   busy      : high whenever the FSM is not idle
//   done      : one-cycle pulse, bcd holds the new result
//   bcd       : {ten-thousands, thousands, hundreds, tens, units} nibbles
module bin2bcd_seq
    import temp_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_t      state;
    logic [BIN_W-1:0] bin_w;
    logic [BCD_W-1:0] bcd_w;
    logic [BCD_W-1:0] bcd_adj;
    logic [4:0]       shcnt;

    // Any nibble >= 5 would overflow past 9 once doubled; pre-add 3
    always_comb begin
        bcd_adj = bcd_w;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_w[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_w[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            bin_w <= '0;
            bcd_w <= '0;
            shcnt <= '0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_w <= bin;
                        bcd_w <= '0;
                        shcnt <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_w <= {bcd_adj[BCD_W-2:0], bin_w[BIN_W-1]};
                    bin_w <= {bin_w[BIN_W-2:0], 1'b0};
                    shcnt <= shcnt + 5'd1;
                    if (shcnt == 5'(BIN_W - 1)) begin
                        bcd   <= {bcd_adj[BCD_W-2:0], bin_w[BIN_W-1]};
                        done  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/temp_seg_display.sv
// temp_seg_display
//   Shows a DS18B20 temperature (hundredths of a degree, separate sign) as
//   -ddd.dd on a 6-digit multiplexed common-anode 7-segment display with
//   leading-zero blanking. Conversion to BCD is sequential; display
//   registers change only when a conversion completes.
//
// Ports:
//   clk, rstn : clock, async active-low reset
//   temp_data : magnitude in 0.01 degC units, clamped to 999.99
//   sign      : 1 = negative
//   seg       : active-low segments, [6:0] = g..a, [7] = dp
//   sel       : active-low one-hot digit select, [5] = sign, [0] = hundredths
module temp_seg_display
    import temp_disp_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIGIT_HZ = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] temp_data,
    input  logic        sign,
    output logic [7:0]  seg,
    output logic [5:0]  sel
);

    localparam int SCAN_DIV = CLK_FREQ / DIGIT_HZ;
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic [19:0]      temp_r;
    logic             sign_r;
    logic [BIN_W-1:0] val;
    logic [BIN_W:0]   key;
    logic [BIN_W:0]   key_lat;
    logic [BIN_W:0]   last;
    logic             valid;
    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    logic [7:0]       disp_seg [NUM_DIGITS];
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       digit_idx;
    logic [7:0]       seg_nxt;

    logic [3:0] dg_hund, dg_tens, dg_units, dg_tenth, dg_hundth;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            temp_r <= '0;
            sign_r <= 1'b0;
        end else begin
            temp_r <= temp_data;
            sign_r <= sign;
        end
    end

    assign val = (temp_r > {3'b000, CLAMP_MAX}) ? CLAMP_MAX : temp_r[BIN_W-1:0];
    assign key = {sign_r, val};

    // A fresh value (or an empty display) starts a conversion as soon as the
    // engine is idle; changes that arrive while it is busy are seen afterwards.
    assign conv_start = !conv_busy && (!valid || (key != last));

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rstn  (rstn),
        .start (conv_start),
        .bin   (val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign dg_hund   = conv_bcd[19:16];
    assign dg_tens   = conv_bcd[15:12];
    assign dg_units  = conv_bcd[11:8];
    assign dg_tenth  = conv_bcd[7:4];
    assign dg_hundth = conv_bcd[3:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_lat <= '0;
            last    <= '0;
            valid   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                disp_seg[i] <= SEG_BLANK;
            end
        end else begin
            if (conv_start) begin
                key_lat <= key;
            end
            if (conv_done) begin
                disp_seg[5] <= key_lat[BIN_W] ? SEG_MINUS : SEG_BLANK;
                disp_seg[4] <= (dg_hund == 4'd0) ? SEG_BLANK : seg_code(dg_hund);
                disp_seg[3] <= (dg_hund == 4'd0 && dg_tens == 4'd0) ?
                               SEG_BLANK : seg_code(dg_tens);
                disp_seg[2] <= seg_code(dg_units) & SEG_DP_MASK;
                disp_seg[1] <= seg_code(dg_tenth);
                disp_seg[0] <= seg_code(dg_hundth);
                last        <= key_lat;
                valid       <= 1'b1;
            end
        end
    end

    always_comb begin
        seg_nxt = SEG_BLANK;
        case (digit_idx)
            3'd0:    seg_nxt = disp_seg[0];
            3'd1:    seg_nxt = disp_seg[1];
            3'd2:    seg_nxt = disp_seg[2];
            3'd3:    seg_nxt = disp_seg[3];
            3'd4:    seg_nxt = disp_seg[4];
            3'd5:    seg_nxt = disp_seg[5];
            default: seg_nxt = SEG_BLANK;
        endcase
    end

    // seg and sel are registered together so a digit never flashes the
    // neighbour's segments at the select change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            seg       <= SEG_BLANK;
            sel       <= 6'h3F;
        end else begin
            seg <= seg_nxt;
            sel <= ~(6'b000001 << digit_idx);
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_temp_seg_display.sv
// tb_temp_seg_display
//   Scoreboarded bench: each stimulus that should trigger a conversion pushes
//   the expected six-digit frame; a negedge monitor checks the scan pattern
//   every cycle and swaps in the next expected frame on each conversion.
module tb_temp_seg_display;

    localparam int SCAN = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [19:0] temp_data = '0;
    logic        sign = 1'b0;
    logic [7:0]  seg;
    logic [5:0]  sel;

    int total = 0;
    int bad = 0;

    logic [47:0] expq [$];
    logic [17:0] model_last;
    int          cyc;
    int          done_cnt = 0;
    logic [47:0] cur;
    logic [47:0] nxt;
    int          pend = 0;

    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    localparam logic [47:0] BLANK48 = {6{8'hFF}};

    temp_seg_display #(.CLK_FREQ(SCAN), .DIGIT_HZ(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .temp_data (temp_data),
        .sign      (sign),
        .seg       (seg),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int t);
        return (t > 99999) ? 99999 : t;
    endfunction

    // Expected frame {d5,...,d0} from the displayed-number rules
    function automatic logic [47:0] frame(input int t, input bit s);
        int v;
        int d4, d3, d2, d1, d0;
        logic [7:0] f [6];
        v  = clampv(t);
        d4 = v / 10000;
        d3 = (v / 1000) % 10;
        d2 = (v / 100) % 10;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        f[5] = s ? 8'hBF : 8'hFF;
        f[4] = (d4 == 0) ? 8'hFF : segtab[d4];
        f[3] = (d4 == 0 && d3 == 0) ? 8'hFF : segtab[d3];
        f[2] = segtab[d2] & 8'h7F;
        f[1] = segtab[d1];
        f[0] = segtab[d0];
        return {f[5], f[4], f[3], f[2], f[1], f[0]};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: scan order and digit contents every cycle
    always @(negedge clk) begin
        int         eidx;
        logic [5:0] esel;
        logic [7:0] eseg;
        if (!rstn) begin
            cur  = BLANK48;
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) cur = nxt;
            end
            if (cyc == 0) begin
                check("post_reset_sel", 64'(sel), 64'h3F);
                check("post_reset_seg", 64'(seg), 64'hFF);
            end else begin
                eidx = ((cyc - 1) / SCAN) % 6;
                esel = ~(6'b000001 << eidx);
                eseg = cur[eidx*8 +: 8];
                check("scan_sel", 64'(sel), 64'(esel));
                check("digit_seg", 64'(seg), 64'(eseg));
            end
            if (dut.u_conv.done) begin
                done_cnt++;
                check("expected_conversion_pending", 64'(expq.size() > 0), 64'd1);
                if (expq.size() > 0) begin
                    nxt  = expq.pop_front();
                    pend = 2;   // display regs load next edge, seg one edge later
                end
            end
        end
    end

    task automatic release_reset();
        temp_data = '0;
        sign      = 1'b0;
        expq.delete();
        repeat (3) @(negedge clk);
        expq.push_back(frame(0, 1'b0));
        model_last = 18'd0;
        rstn = 1'b1;
    endtask

    task automatic reset_mid_scan();
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_seg", 64'(seg), 64'hFF);
        check("async_reset_sel", 64'(sel), 64'h3F);
        release_reset();
    endtask

    task automatic apply(input int t, input bit s, input int settle, input bit chk_lat);
        logic [17:0] key;
        int          lat;
        @(negedge clk);
        temp_data = 20'(t);
        sign      = s;
        key = {s, 17'(clampv(t))};
        if (key != model_last) begin
            expq.push_back(frame(t, s));
            model_last = key;
            if (chk_lat) begin
                lat = 0;
                for (int k = 1; k <= 40; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (dut.u_conv.done) begin
                        lat = k;
                        break;
                    end
                end
                check("load_latency", 64'(lat), 64'd19);
            end
        end
        repeat (settle) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int t;
        bit s;
        release_reset();
        repeat (70) @(negedge clk);

        apply(2500,   1'b0, 70, 1'b1);
        apply(5500,   1'b1, 70, 1'b1);
        apply(12500,  1'b0, 70, 1'b1);
        apply(0,      1'b0, 70, 1'b1);
        apply(0,      1'b1, 70, 1'b1);
        apply(150000, 1'b0, 70, 1'b1);
        apply(120000, 1'b0, 70, 1'b0);

        // change while the engine is shifting
        apply(2500,   1'b0, 8,  1'b0);
        apply(3125,   1'b0, 90, 1'b0);

        t = 0;
        s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i % 5 != 4) begin
                t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100000, 1048575))
                                                : int'($urandom_range(0, 99999));
                s = 1'($urandom_range(0, 1));
            end
            apply(t, s, 70, 1'b1);
        end

        // steady input: no further conversions
        dc = done_cnt;
        repeat (1000) @(negedge clk);
        check("steady_no_conversion", 64'(done_cnt), 64'(dc));
        check("steady_fsm_idle", 64'(dut.u_conv.busy), 64'd0);

        // reset while a conversion is running
        apply(77777, 1'b1, 8, 1'b0);
        reset_mid_scan();
        repeat (70) @(negedge clk);
        apply(9999, 1'b1, 70, 1'b1);

        check("all_expected_conversions_seen", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
